// File: rtl/descrambler_sync.sv
// Frame-synchronous x^7+x^4+1 descrambler that self-seeds from the first 7 SERVICE bits.
// Define SERVICE_CHECK_EN to enable the sticky SERVICE/seed error flag; otherwise error is tied low.
module descrambler_sync #(
   parameter int FRAME_BITS = 4096,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic in_valid,
   input  logic in_bit,
   output logic out_bit,
   output logic out_valid,
   output logic busy,
   output logic done,
   output logic error
);

   typedef enum logic [1:0] {IDLE, SEED, SVC, DATA} state_t;

   localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(6);
   localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(15);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);

   state_t           state, state_nxt;
   logic [6:0]       s, s_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             out_bit_nxt, out_valid_nxt, busy_nxt, done_nxt;
   logic             fb;

   // s[6] is the oldest keystream bit, so the next keystream bit is s[6]^s[3]
   assign fb = s[6] ^ s[3];

   always_comb begin
      state_nxt     = state;
      s_nxt         = s;
      cnt_nxt       = cnt;
      out_bit_nxt   = out_bit;
      out_valid_nxt = 1'b0;
      done_nxt      = 1'b0;
      busy_nxt      = busy;
      if (state == IDLE) busy_nxt = 1'b0;
      if (in_valid) begin
         if (start) begin
            state_nxt = SEED;
            s_nxt     = {s[5:0], in_bit};
            cnt_nxt   = CNT_W'(1);
            busy_nxt  = 1'b1;
         end else begin
            case (state)
               SEED: begin
                  s_nxt   = {s[5:0], in_bit};
                  cnt_nxt = cnt + CNT_W'(1);
                  if (cnt == SEED_LAST) state_nxt = SVC;
               end
               SVC: begin
                  s_nxt = {s[5:0], fb};
                  if (cnt == SVC_LAST) begin
                     state_nxt = DATA;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
               DATA: begin
                  s_nxt         = {s[5:0], fb};
                  out_bit_nxt   = in_bit ^ fb;
                  out_valid_nxt = 1'b1;
                  if (cnt == DATA_LAST) begin
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s         <= '0;
         cnt       <= '0;
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         s         <= s_nxt;
         cnt       <= cnt_nxt;
         out_bit   <= out_bit_nxt;
         out_valid <= out_valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

`ifdef SERVICE_CHECK_EN
   logic err_set, err_clr;

   // Flag an all-zero recovered seed, or any reserved SERVICE bit that descrambles to 1
   always_comb begin
      err_clr = in_valid & start;
      err_set = 1'b0;
      if (in_valid && !start) begin
         if (state == SEED && cnt == SEED_LAST && {s[5:0], in_bit} == 7'd0) err_set = 1'b1;
         if (state == SVC && (in_bit ^ fb)) err_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       error <= 1'b0;
      else if (err_clr) error <= 1'b0;
      else if (err_set) error <= 1'b1;
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_descrambler_sync.sv
// Bench for descrambler_sync: keystream-recurrence reference model, directed and randomized frames.
module tb_descrambler_sync;
   localparam int FB = 24;
   localparam int N  = 16 + FB;
`ifdef SERVICE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, start, in_valid, in_bit;
   logic out_bit, out_valid, busy, done, error;

   int vec = 0;
   int miss = 0;

   bit stim[N];
   bit ks[N];
   bit err_exp[N];
   bit exp_out[FB];

   always #5 clk = ~clk;

   descrambler_sync #(.FRAME_BITS(FB), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_bit(in_bit),
      .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done), .error(error)
   );

   // Keystream follows ks[n] = ks[n-7] ^ ks[n-4]; the first 7 received bits are keystream itself
   task automatic model();
      bit bad_frame;
      bit seed_zero;
      bad_frame = 1'b0;
      seed_zero = 1'b1;
      for (int n = 0; n < N; n++) begin
         ks[n] = (n < 7) ? stim[n] : (ks[n-7] ^ ks[n-4]);
         if (n < 7 && stim[n]) seed_zero = 1'b0;
         if (n == 6 && seed_zero) bad_frame = 1'b1;
         if (n >= 7 && n < 16 && (stim[n] ^ ks[n])) bad_frame = 1'b1;
         err_exp[n] = CHK & bad_frame;
         if (n >= 16) exp_out[n-16] = stim[n] ^ ks[n];
      end
   endtask

   task automatic load_literal(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) stim[i] = v[N-1-i];
   endtask

   task automatic make_legal();
      int seed;
      seed = $urandom_range(1, 127);
      for (int n = 0; n < N; n++) begin
         if (n < 7) stim[n] = seed[6-n];
         ks[n] = (n < 7) ? stim[n] : (ks[n-7] ^ ks[n-4]);
         if (n >= 7 && n < 16) stim[n] = ks[n];
         else if (n >= 16) stim[n] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send(input bit b, input bit v, input bit st);
      in_bit   = b;
      in_valid = v;
      start    = st;
      @(posedge clk);
      #1;
   endtask

   // Drive stim[0..stop-1] with start on bit 0; stall_mode 0=none, 1=alternate, 2=random
   task automatic run_frame(input int stall_mode, input int stop);
      bit stall;
      model();
      for (int i = 0; i < stop; i++) begin
         send(stim[i], 1'b1, i == 0);
         vec++;
         if (out_valid !== (i >= 16)) begin
            miss++; $display("FAIL out_valid bit %0d: got %b want %b", i, out_valid, i >= 16);
         end
         if (i >= 16) begin
            vec++;
            if (out_bit !== exp_out[i-16]) begin
               miss++; $display("FAIL out_bit data %0d: got %b want %b", i - 16, out_bit, exp_out[i-16]);
            end
         end
         vec++;
         if (done !== (i == N - 1)) begin
            miss++; $display("FAIL done bit %0d: got %b want %b", i, done, i == N - 1);
         end
         vec++;
         if (busy !== 1'b1) begin
            miss++; $display("FAIL busy bit %0d: got %b want 1", i, busy);
         end
         vec++;
         if (error !== err_exp[i]) begin
            miss++; $display("FAIL error bit %0d: got %b want %b", i, error, err_exp[i]);
         end
         stall = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 2) == 0);
         if (stall && i < N - 1) begin
            send(1'($urandom_range(0, 1)), 1'b0, stall_mode == 2);
            vec++;
            if (out_valid !== 1'b0 || done !== 1'b0) begin
               miss++; $display("FAIL stall after bit %0d: out_valid=%b done=%b want 0 0", i, out_valid, done);
            end
            vec++;
            if (error !== err_exp[i] || busy !== 1'b1) begin
               miss++; $display("FAIL stall hold bit %0d: error=%b busy=%b want %b 1", i, error, busy, err_exp[i]);
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic check_idle_after(input string tag);
      send(1'b1, 1'b0, 1'b0);
      vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
         miss++; $display("FAIL %s end: busy=%b out_valid=%b done=%b want 0 0 0", tag, busy, out_valid, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if ({out_bit, out_valid, busy, done, error} !== 5'b0) begin
         miss++; $display("FAIL reset outputs: got %b want 00000", {out_bit, out_valid, busy, done, error});
      end
      rst_n = 1'b1;
      send(1'b1, 1'b1, 1'b0);
      vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miss++; $display("FAIL idle ignores bits: busy=%b out_valid=%b want 0 0", busy, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_zero_data();
      load_literal(40'b0000111011110010_11001001_00000010_00100110);
      run_frame(0, N);
      check_idle_after("zero_data");
   endtask

   task automatic test_pattern();
      logic [23:0] pat;
      pat = 24'hA5C3F0;
      load_literal(40'b0000111011110010_11001001_00000010_00100110);
      for (int k = 0; k < FB; k++) stim[16+k] = stim[16+k] ^ pat[23-k];
      run_frame(0, N);
      check_idle_after("pattern");
   endtask

   task automatic test_service_flip();
      load_literal(40'b0000111011110010_11001001_00000010_00100110);
      stim[12] = ~stim[12];
      run_frame(0, N);
      check_idle_after("service_flip");
   endtask

   task automatic test_zero_seed();
      for (int n = 0; n < N; n++) stim[n] = (n < 16) ? 1'b0 : 1'($urandom_range(0, 1));
      run_frame(0, N);
      check_idle_after("zero_seed");
   endtask

   task automatic test_stall();
      load_literal(40'b0000111011110010_11001001_00000010_00100110);
      run_frame(1, N);
      check_idle_after("stall");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         make_legal();
         if (r % 2 == 1) stim[$urandom_range(7, 15)] ^= 1'b1;
         run_frame(2, N);
         check_idle_after("random");
      end
   endtask

   task automatic test_abort();
      make_legal();
      run_frame(0, 26);
      make_legal();
      run_frame(0, N);
      check_idle_after("abort");
   endtask

   task automatic test_reset_mid();
      make_legal();
      stim[21] = ~ks[21];
      run_frame(0, 22);
      #2;
      rst_n = 1'b0;
      #1;
      vec++;
      if ({out_bit, out_valid, busy, done, error} !== 5'b0) begin
         miss++; $display("FAIL reset mid-frame: got %b want 00000", {out_bit, out_valid, busy, done, error});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(1'b1, 1'b1, 1'b0);
      vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miss++; $display("FAIL idle after reset: busy=%b out_valid=%b want 0 0", busy, out_valid);
      end
      make_legal();
      run_frame(0, N);
      check_idle_after("reset_mid");
   endtask

   initial begin
      test_reset();
      test_zero_data();
      test_pattern();
      test_service_flip();
      test_zero_seed();
      test_stall();
      test_random();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
